vga_sync_ctrl: RTL and testbench

VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

---
 rtl/vga_sync_ctrl.sv | 110 +++++++++++
 tb/tb_vga_sync_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_ctrl.sv
// VGA 640x480 horizontal timing, sync/blank decode and a vblank-aligned update handshake.
// Optional macro SYNC_PIPE_EN adds one register stage to hsync/vsync/video_on/frame_tick.
module vga_sync_ctrl (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic [15:0] V_Count_Value,
  output logic        enable_V_Counter,
  output logic [15:0] H_Count_Value,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_tick,
  input  logic        upd_req,
  output logic        upd_ack
);

  localparam logic [9:0]  H_LAST       = 10'd799;
  localparam logic [9:0]  H_VISIBLE    = 10'd640;
  localparam logic [9:0]  H_SYNC_START = 10'd656;
  localparam logic [9:0]  H_SYNC_END   = 10'd751;
  localparam logic [15:0] V_VISIBLE    = 16'd480;
  localparam logic [15:0] V_SYNC_START = 16'd490;
  localparam logic [15:0] V_SYNC_END   = 16'd491;
  localparam logic [15:0] V_LAST       = 16'd524;

  typedef enum logic [1:0] {IDLE, WAIT_VB, GRANT, RELEASE} upd_state_e;

  logic [9:0] h_cnt_q, h_cnt_d;
  upd_state_e state_q, state_d;
  logic       h_end, ft_raw, blank_end;
  logic       hsync_d, vsync_d, video_on_d, frame_tick_d;

  always_comb begin
    h_cnt_d = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) h_cnt_q <= 10'd0;
    else       h_cnt_q <= h_cnt_d;
  end

  assign H_Count_Value = {6'd0, h_cnt_q};
  assign h_end         = (h_cnt_q == H_LAST);
  assign ft_raw        = (V_Count_Value == V_VISIBLE) && (h_cnt_q == 10'd0);
  assign blank_end     = (V_Count_Value == V_LAST) && h_end;

  // Decodes are forced to their idle levels while reset is held.
  always_comb begin
    hsync_d      = 1'b1;
    vsync_d      = 1'b1;
    video_on_d   = 1'b0;
    frame_tick_d = 1'b0;
    if (!reset) begin
      hsync_d      = !((h_cnt_q >= H_SYNC_START) && (h_cnt_q <= H_SYNC_END));
      vsync_d      = !((V_Count_Value >= V_SYNC_START) && (V_Count_Value <= V_SYNC_END));
      video_on_d   = (h_cnt_q < H_VISIBLE) && (V_Count_Value < V_VISIBLE);
      frame_tick_d = ft_raw;
    end
  end

`ifdef SYNC_PIPE_EN
  logic hsync_q, vsync_q, video_on_q, frame_tick_q;

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign hsync      = reset ? 1'b1 : hsync_q;
  assign vsync      = reset ? 1'b1 : vsync_q;
  assign video_on   = reset ? 1'b0 : video_on_q;
  assign frame_tick = reset ? 1'b0 : frame_tick_q;
`else
  assign hsync      = hsync_d;
  assign vsync      = vsync_d;
  assign video_on   = video_on_d;
  assign frame_tick = frame_tick_d;
`endif

  // The FSM always follows the unregistered frame tick so grant timing is build-independent.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (upd_req) state_d = WAIT_VB;
      WAIT_VB: if (!upd_req) state_d = IDLE;
               else if (ft_raw) state_d = GRANT;
      GRANT:   if (!upd_req || blank_end) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign enable_V_Counter = !reset && h_end;
  assign upd_ack          = !reset && (state_q == GRANT);

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Randomized bench for vga_sync_ctrl against a behavioural timing/handshake model.
module tb_vga_sync_ctrl;

`ifdef SYNC_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] V_Count_Value = 16'd0;
  logic        upd_req = 1'b0;
  logic        enable_V_Counter, hsync, vsync, video_on, frame_tick, upd_ack;
  logic [15:0] H_Count_Value;

  vga_sync_ctrl dut (
    .clk_25MHz(clk), .reset(rst), .V_Count_Value(V_Count_Value),
    .enable_V_Counter(enable_V_Counter), .H_Count_Value(H_Count_Value),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_tick(frame_tick),
    .upd_req(upd_req), .upd_ack(upd_ack)
  );

  always #20 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pixel position, line counter, and the update handshake phase.
  int  m_h = 0, m_v = 0;
  bit  pending = 0, granted = 0, cooldown = 0;
  bit  started = 0;
  bit  v_force_en = 0;
  logic [15:0] v_force = 16'd0;
  logic p_hs = 1'b1, p_vs = 1'b1, p_vo = 1'b0, p_ft = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t h=%0d v=%0d)", nm, act, exp, $time, m_h, m_v);
    end
  endtask

  always @(posedge clk) begin
    int  vin;
    bit  ft;
    vin = V_Count_Value;
    ft  = (vin == 480) && (m_h == 0);
    if (rst) begin
      m_h = 0; pending = 0; granted = 0; cooldown = 0;
    end else begin
      if (cooldown) cooldown = 0;
      else if (granted) begin
        if (!upd_req || (vin == 524 && m_h == 799)) begin granted = 0; cooldown = 1; end
      end else if (pending) begin
        if (!upd_req) pending = 0;
        else if (ft) begin pending = 0; granted = 1; end
      end else if (upd_req) pending = 1;
      if (m_h == 799) begin
        m_h = 0;
        m_v = (m_v >= 524) ? 0 : m_v + 1;
      end else m_h = m_h + 1;
    end
    started = 1;
    #1 V_Count_Value = v_force_en ? v_force : 16'(m_v);
  end

  always @(negedge clk) begin
    int   v;
    logic c_hs, c_vs, c_vo, c_ft, e_hs, e_vs, e_vo, e_ft;
    if (started) begin
      v    = V_Count_Value;
      c_hs = rst ? 1'b1 : !(m_h >= 656 && m_h <= 751);
      c_vs = rst ? 1'b1 : !(v >= 490 && v <= 491);
      c_vo = rst ? 1'b0 : (m_h < 640 && v < 480);
      c_ft = rst ? 1'b0 : (v == 480 && m_h == 0);
      if (PIPE != 0) begin
        e_hs = rst ? 1'b1 : p_hs; e_vs = rst ? 1'b1 : p_vs;
        e_vo = rst ? 1'b0 : p_vo; e_ft = rst ? 1'b0 : p_ft;
      end else begin
        e_hs = c_hs; e_vs = c_vs; e_vo = c_vo; e_ft = c_ft;
      end
      chk("h_count", H_Count_Value, 16'(m_h));
      chk("enable_v", {15'd0, enable_V_Counter}, {15'd0, !rst && m_h == 799});
      chk("upd_ack", {15'd0, upd_ack}, {15'd0, !rst && granted});
      chk("hsync", {15'd0, hsync}, {15'd0, e_hs});
      chk("vsync", {15'd0, vsync}, {15'd0, e_vs});
      chk("video_on", {15'd0, video_on}, {15'd0, e_vo});
      chk("frame_tick", {15'd0, frame_tick}, {15'd0, e_ft});
      p_hs = c_hs; p_vs = c_vs; p_vo = c_vo; p_ft = c_ft;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic set_v(input int v);
    m_v = v;
    V_Count_Value = 16'(v);
  endtask

  task automatic wait_vh(input int v, input int h, input int max, input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(m_v == v && m_h == h) && n < max);
    chk(nm, {15'd0, (m_v == v && m_h == h)}, 16'd1);
  endtask

  initial begin
    int en_cnt, hs_cnt, hs_first, wraps, prev_h, r;
    logic [3:0] vs_tab;

    cyc(3);
    rst = 1'b0;

    // One full line: counter wrap, strobe count, hsync width and start.
    en_cnt = 0; hs_cnt = 0; hs_first = -1; wraps = 0; prev_h = -1;
    for (int i = 0; i < 801; i++) begin
      @(negedge clk);
      if (prev_h == 799 && H_Count_Value == 16'd0) wraps++;
      prev_h = H_Count_Value;
      if (i < 800) begin
        if (enable_V_Counter) en_cnt++;
        if (!hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = H_Count_Value;
        end
      end
    end
    chk("line_wrap", 16'(wraps), 16'd1);
    chk("line_enable_cnt", 16'(en_cnt), 16'd1);
    chk("line_hsync_len", 16'(hs_cnt), 16'd96);
    chk("line_hsync_start", 16'(hs_first), 16'(656 + PIPE));

    // vsync around the sync lines; the registered build lags one cycle.
    vs_tab = (PIPE != 0) ? 4'b0011 : 4'b1001;
    @(posedge clk); #2;
    v_force_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v_force = 16'(489 + i);
      V_Count_Value = v_force;
      @(negedge clk);
      chk($sformatf("vsync_v%0d", 489 + i), {15'd0, vsync}, {15'd0, vs_tab[i]});
      @(posedge clk); #2;
    end
    @(negedge clk);
    chk("vsync_after", {15'd0, vsync}, 16'd1);
    @(posedge clk); #2;
    v_force_en = 1'b0;
    set_v(100);

    // Request held from the visible area: grant at the first vblank cycle.
    upd_req = 1'b1;
    cyc(10);
    set_v(479);
    wait_vh(480, 0, 2000, "reach_ft");
    chk("ack_at_ft", {15'd0, upd_ack}, 16'd0);
    @(negedge clk);
    chk("ack_after_ft", {15'd0, upd_ack}, 16'd1);
    cyc(50);
    upd_req = 1'b0;
    @(negedge clk);
    chk("ack_held", {15'd0, upd_ack}, 16'd1);
    @(negedge clk);
    chk("ack_release", {15'd0, upd_ack}, 16'd0);
    cyc(5);

    // Request rising together with frame_tick waits a full frame.
    set_v(479);
    wait_vh(479, 799, 2000, "reach_pre_ft");
    @(posedge clk); #2;
    upd_req = 1'b1;
    wait_vh(481, 0, 2000, "reach_481");
    chk("no_grant_same_frame", {15'd0, upd_ack}, 16'd0);
    cyc(1);
    set_v(479);
    wait_vh(480, 1, 2000, "reach_grant2");
    chk("grant_next_frame", {15'd0, upd_ack}, 16'd1);

    // Request held through blanking: timeout at end of line 524, regrant next frame.
    wait_vh(524, 799, 40000, "reach_blank_end");
    chk("ack_end_blank", {15'd0, upd_ack}, 16'd1);
    @(negedge clk);
    chk("ack_timeout", {15'd0, upd_ack}, 16'd0);
    cyc(1);
    set_v(478);
    wait_vh(480, 1, 3000, "reach_regrant");
    chk("regrant", {15'd0, upd_ack}, 16'd1);

    // Reset during grant.
    cyc(20);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant_ack", {15'd0, upd_ack}, 16'd0);
    chk("rst_grant_h", H_Count_Value, 16'd0);
    cyc(1);
    rst = 1'b0;
    upd_req = 1'b0;

    // Randomized traffic, line jumps (including out-of-range lines) and resets.
    for (int i = 0; i < 8000; i++) begin
      cyc(1);
      if ($urandom_range(0, 63) == 0) upd_req = ~upd_req;
      r = $urandom_range(0, 299);
      if (r == 0)      set_v(479);
      else if (r == 1) set_v(523);
      else if (r == 2) set_v($urandom_range(0, 524));
      else if (r == 3) set_v($urandom_range(526, 65535));
      rst = ($urandom_range(0, 1999) == 0);
    end
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
